// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: drains a burst from fifo_queue (fifo_deq/fifo_data/fifo_empty) onto a valid/ready port (m_valid/m_data/m_ready), with start/burst_len/abort control and busy/done/word_count status
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 16,
  parameter int CNT_W = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      burst_len,
  input  logic                  abort,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_deq,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      word_count
);
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PRESENT, DONE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] len, cnt_inc;
  logic accept, last;
  assign cnt_inc = word_count + CNT_W'(1);
  assign accept = state == PRESENT && m_ready && !abort;
  assign last = cnt_inc == len;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start && burst_len != '0 ? FETCH : IDLE;
      FETCH:   state_nxt = abort ? IDLE : fifo_empty ? FETCH : CAPTURE;
      CAPTURE: state_nxt = abort ? IDLE : PRESENT;
      PRESENT: state_nxt = abort ? IDLE : accept ? (last ? DONE : FETCH) : PRESENT;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    fifo_deq = state == FETCH && !fifo_empty && !reset;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data <= '0;
      done <= 1'b0;
      word_count <= '0;
      len <= '0;
    end else begin
      done <= (state == IDLE && start && burst_len == '0) || (accept && last);
      if (state == IDLE && start) begin
        word_count <= '0;
        len <= burst_len > CNT_W'(MAX_BURST) ? CNT_W'(MAX_BURST) : burst_len;
      end
      if (state == CAPTURE && !abort) begin
        m_data <= fifo_data;
        m_valid <= 1'b1;
      end
      if (state == PRESENT && (m_ready || abort)) m_valid <= 1'b0;
      if (accept) word_count <= cnt_inc;
    end
  end
endmodule
